// File: rtl/conv_mac_axil_slave.sv
// conv_mac_axil_slave
//   AXI4-Lite register slave with a sequential 4-tap signed MAC engine.
//   Word map: 0x00 CTRL (W, self-clearing), 0x04 STATUS, 0x08 PIXELS,
//   0x0C WEIGHTS, 0x10 BIAS, 0x14 RESULT, 0x18 SCRATCH, 0x1C ID.
// Ports:
//   ACLK, ARESETN          clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*        write address / data / response channels
//   S_AXI_AR*/R*           read address / data channels
//   done_irq               level copy of STATUS.DONE
module conv_mac_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] ID_VALUE           = 32'hC0A00001
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              done_irq
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  localparam logic [2:0] W_CTRL    = 3'd0;
  localparam logic [2:0] W_STATUS  = 3'd1;
  localparam logic [2:0] W_PIXELS  = 3'd2;
  localparam logic [2:0] W_WEIGHTS = 3'd3;
  localparam logic [2:0] W_BIAS    = 3'd4;
  localparam logic [2:0] W_RESULT  = 3'd5;
  localparam logic [2:0] W_SCRATCH = 3'd6;
  localparam logic [2:0] W_ID      = 3'd7;

  typedef enum logic {S_IDLE, S_RUN} mac_state_e;

  // Bus-side registers
  logic          awready_q, wready_q, bvalid_q;
  logic          arready_q, rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] pixels_q, weights_q, bias_q, scratch_q;
  logic          start_pend_q, clr_pend_q;

  // MAC engine registers
  mac_state_e    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] pix_sh_q, pix_sh_d;
  logic [DW-1:0] wt_sh_q, wt_sh_d;
  logic [DW-1:0] result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          wr_fire_c, rd_fire_c;
  logic [2:0]    wr_word_c, rd_word_c;
  logic [DW-1:0] rd_mux_c;

  logic signed [7:0]  pix_byte_c, wt_byte_c;
  logic signed [15:0] prod_c;
  logic [DW-1:0]      acc_sum_c;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Upper address bits alias: only the word index [4:2] is decoded.
  assign wr_word_c = S_AXI_AWADDR[4:2];
  assign rd_word_c = S_AXI_ARADDR[4:2];

  // Accept a write only when both channels are present and the response slot is free.
  assign wr_fire_c = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
  assign rd_fire_c = S_AXI_ARVALID && !arready_q && !rvalid_q;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(SW); i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Read data mux; sampled at address acceptance so a same-cycle write is not yet visible.
  always_comb begin
    rd_mux_c = '0;
    case (rd_word_c)
      W_CTRL:    rd_mux_c = '0;
      W_STATUS:  rd_mux_c = DW'({done_q, busy_q});
      W_PIXELS:  rd_mux_c = pixels_q;
      W_WEIGHTS: rd_mux_c = weights_q;
      W_BIAS:    rd_mux_c = bias_q;
      W_RESULT:  rd_mux_c = result_q;
      W_SCRATCH: rd_mux_c = scratch_q;
      W_ID:      rd_mux_c = DW'(ID_VALUE);
      default:   rd_mux_c = '0;
    endcase
  end

  // AXI handshakes and the RW register bank
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      pixels_q     <= '0;
      weights_q    <= '0;
      bias_q       <= '0;
      scratch_q    <= '0;
      start_pend_q <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      awready_q <= wr_fire_c;
      wready_q  <= wr_fire_c;

      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      else if (awready_q)           bvalid_q <= 1'b1;

      arready_q <= rd_fire_c;
      if (rd_fire_c) rdata_q <= rd_mux_c;

      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      else if (arready_q)           rvalid_q <= 1'b1;

      // CTRL bits are one-cycle pulses into the MAC engine.
      start_pend_q <= wr_fire_c && (wr_word_c == W_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
      clr_pend_q   <= wr_fire_c && (wr_word_c == W_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

      if (wr_fire_c) begin
        case (wr_word_c)
          W_PIXELS:  pixels_q  <= apply_strb(pixels_q,  S_AXI_WDATA, S_AXI_WSTRB);
          W_WEIGHTS: weights_q <= apply_strb(weights_q, S_AXI_WDATA, S_AXI_WSTRB);
          W_BIAS:    bias_q    <= apply_strb(bias_q,    S_AXI_WDATA, S_AXI_WSTRB);
          W_SCRATCH: scratch_q <= apply_strb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
          default:   ;
        endcase
      end
    end
  end

  // One signed 8x8 tap per RUN cycle, sign-extended into the wrapping accumulator.
  assign pix_byte_c = pix_sh_q[{idx_q, 3'b000} +: 8];
  assign wt_byte_c  = wt_sh_q[{idx_q, 3'b000} +: 8];
  assign prod_c     = 16'(pix_byte_c) * 16'(wt_byte_c);
  assign acc_sum_c  = acc_q + DW'(prod_c);

  // MAC state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      pix_sh_q <= '0;
      wt_sh_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      pix_sh_q <= pix_sh_d;
      wt_sh_q  <= wt_sh_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // MAC next-state: START in IDLE snapshots operands; START while running is ignored.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    pix_sh_d = pix_sh_q;
    wt_sh_d  = wt_sh_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      S_IDLE: begin
        if (start_pend_q) begin
          pix_sh_d = pixels_q;
          wt_sh_d  = weights_q;
          acc_d    = bias_q;
          idx_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = S_RUN;
        end else if (clr_pend_q) begin
          done_d = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = acc_sum_c;
        idx_d = 2'(idx_q + 2'd1);
        if (idx_q == 2'd3) begin
          result_d = acc_sum_c;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign done_irq      = done_q;

endmodule
